// File: rtl/act_skew_feeder.sv
// Activation skew feeder: per-row delay chains that turn one accepted vector per cycle
// into the diagonal wavefront of the systolic array. Macro ACT_SIGNED_EN selects sign-extension.

module act_skew_lane #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         vin,
    output logic [W-1:0] dout,
    output logic         vout
);
    logic [DEPTH-1:0][W-1:0] dat_pipe;
    logic [DEPTH-1:0]        vld_pipe;

    // The array never stalls, so the chain shifts every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dat_pipe <= '0;
            vld_pipe <= '0;
        end else begin
            dat_pipe[0] <= din;
            vld_pipe[0] <= vin;
            for (int i = 1; i < DEPTH; i++) begin
                dat_pipe[i] <= dat_pipe[i-1];
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign dout = dat_pipe[DEPTH-1];
    assign vout = vld_pipe[DEPTH-1];
endmodule

module act_skew_feeder #(
    parameter int ROWS      = 4,
    parameter int DATA_SIZE = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROWS*DATA_SIZE-1:0]     in_data,
    input  logic                          in_last,
    output logic [ROWS*2*DATA_SIZE-1:0]   data_west_out,
    output logic [ROWS-1:0]               west_valid,
    output logic                          busy,
    output logic [31:0]                   vec_count,
    output logic                          frame_done
);
    localparam int EW = 2 * DATA_SIZE;
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] drain_cnt;
    logic          accept;

    assign in_ready = (state != DRAIN);
    assign accept   = in_valid && in_ready;

    // frame_done is scheduled one edge early so it lands with the last vector on row ROWS-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            vec_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        vec_count <= (state == IDLE) ? 32'd1 : vec_count + 32'd1;
                        busy      <= 1'b1;
                        if (in_last) begin
                            state      <= DRAIN;
                            drain_cnt  <= CW'(ROWS - 1);
                            frame_done <= (ROWS == 1);
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt  <= drain_cnt - CW'(1);
                        frame_done <= (drain_cnt == CW'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_SIZE-1:0] act;
        logic [DATA_SIZE-1:0] fill;
        logic [EW-1:0]        ext;

        assign act = in_data[r*DATA_SIZE +: DATA_SIZE];
`ifdef ACT_SIGNED_EN
        assign fill = {DATA_SIZE{act[DATA_SIZE-1]}};
`else
        assign fill = '0;
`endif
        // Non-accept cycles inject a zero bubble into stage 0.
        assign ext = accept ? {fill, act} : '0;

        act_skew_lane #(.DEPTH(r + 1), .W(EW)) u_lane (
            .clock (clock),
            .reset (reset),
            .din   (ext),
            .vin   (accept),
            .dout  (data_west_out[r*EW +: EW]),
            .vout  (west_valid[r])
        );
    end
endmodule

// File: tb/tb_act_skew_feeder.sv
// Bench for act_skew_feeder: directed and random traffic against a delay-line/frame model.
module tb_act_skew_feeder;
    localparam int ROWS = 4;
    localparam int DS   = 8;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [ROWS*DS-1:0]     in_data = '0;
    logic                   in_last = 1'b0;
    logic [ROWS*2*DS-1:0]   data_west_out;
    logic [ROWS-1:0]        west_valid;
    logic                   busy;
    logic [31:0]            vec_count;
    logic                   frame_done;

    int checks = 0;
    int errors = 0;

    act_skew_feeder #(.ROWS(ROWS), .DATA_SIZE(DS)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .data_west_out(data_west_out),
        .west_valid(west_valid), .busy(busy), .vec_count(vec_count), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct { logic [ROWS*DS-1:0] d; bit v; } ent_t;
    ent_t hist[$];          // hist[k] = what was accepted k edges ago
    bit   in_frame;
    int   drain_left;
    logic [31:0] vcount;

`ifdef ACT_SIGNED_EN
    localparam logic [15:0] EXP80 = 16'hFF80;
`else
    localparam logic [15:0] EXP80 = 16'h0080;
`endif

    function automatic logic [15:0] ext8(input logic [7:0] b);
`ifdef ACT_SIGNED_EN
        int s;
        s = $signed(b);
        return 16'(s);
`else
        return 16'(b);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit mready();
        return drain_left == 0;
    endfunction

    task automatic model_reset();
        ent_t b;
        b.d = '0; b.v = 0;
        hist.delete();
        for (int i = 0; i < ROWS; i++) hist.push_back(b);
        in_frame = 0; drain_left = 0; vcount = 0;
    endtask

    task automatic model_edge(input bit acc, input bit last, input logic [ROWS*DS-1:0] d);
        ent_t e;
        e.d = d; e.v = acc;
        hist.push_front(e);
        void'(hist.pop_back());
        if (acc) begin
            vcount = in_frame ? vcount + 1 : 32'd1;
            in_frame = 1;
            if (last) begin
                in_frame = 0;
                drain_left = ROWS;
            end
        end else if (drain_left > 0) begin
            drain_left--;
        end
    endtask

    task automatic check_all();
        logic [ROWS*2*DS-1:0] ed;
        logic [ROWS-1:0]      ev;
        for (int r = 0; r < ROWS; r++) begin
            ev[r] = hist[r].v;
            ed[r*2*DS +: 2*DS] = hist[r].v ? ext8(hist[r].d[r*DS +: DS]) : 16'h0;
        end
        chk("west_data", 64'(data_west_out), 64'(ed));
        chk("west_valid", 64'(west_valid), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(mready()));
        chk("busy", 64'(busy), 64'(in_frame || drain_left > 0));
        chk("vec_count", 64'(vec_count), 64'(vcount));
        chk("frame_done", 64'(frame_done), 64'(drain_left == 1));
    endtask

    task automatic tick(input bit v, input bit l, input logic [ROWS*DS-1:0] d);
        bit acc;
        in_valid = v; in_last = l; in_data = d;
        acc = v && mready();
        @(posedge clock); #1;
        model_edge(acc, l, d);
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, 64'(data_west_out), 64'h0);
        chk({tag, "_valid"}, 64'(west_valid), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_cnt"}, 64'(vec_count), 64'h0);
        chk({tag, "_done"}, 64'(frame_done), 64'h0);
        chk({tag, "_ready"}, 64'(in_ready), 64'h1);
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic reset_mid();
        #3 reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic settle();
        for (int i = 0; i < 20 && (in_frame || drain_left > 0); i++)
            tick(in_frame && mready(), 1'b1, ROWS*DS'($urandom));
    endtask

    initial begin
        model_reset();
        #2 check_reset_outputs("por");
        @(posedge clock); #1;
        reset = 1'b0;
        tick(0, 0, '0);
        tick(0, 1, 32'hDEADBEEF);   // in_last without valid is ignored

        // single-vector frame
        tick(1, 1, 32'h04030201);
        chk("single_lane0", 64'(data_west_out[15:0]), 64'h0001);
        chk("single_ready", 64'(in_ready), 64'h0);
        tick(0, 0, '0);
        tick(0, 0, '0);
        tick(0, 0, '0);
        chk("single_lane3", 64'(data_west_out[63:48]), 64'h0004);
        chk("single_done", 64'(frame_done), 64'h1);
        chk("single_cnt", 64'(vec_count), 64'h1);
        tick(0, 0, '0);
        chk("single_ready_back", 64'(in_ready), 64'h1);

        // extension
        tick(1, 1, 32'h7F_01_FF_80);
        chk("ext80", 64'(data_west_out[15:0]), 64'(EXP80));
        settle();

        // streaming 1..5
        for (int i = 1; i <= 5; i++) tick(1, i == 5, {4{8'(i)}});
        chk("stream_cnt", 64'(vec_count), 64'h5);
        settle();

        // bubble in the middle
        tick(1, 0, 32'hA1A2A3A4);
        tick(0, 0, 32'hFFFFFFFF);
        tick(1, 1, 32'hB1B2B3B4);
        chk("bubble_cnt", 64'(vec_count), 64'h2);
        settle();

        // random traffic
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, ROWS*DS'($urandom));
        settle();

        // reset mid-frame
        tick(1, 0, 32'h11223344);
        tick(1, 0, 32'h55667788);
        tick(1, 0, 32'h99AABBCC);
        reset_mid();
        for (int i = 0; i < 8; i++) tick(0, 0, '0);
        tick(1, 0, 32'h0F0E0D0C);
        chk("fresh_cnt", 64'(vec_count), 64'h1);
        tick(1, 1, 32'h80808080);
        settle();
        tick(0, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/act_skew_feeder.md
# act_skew_feeder

Activation feeder directly upstream of the systolic MAC array. Accepts one vector of ROWS activations per cycle over a valid/ready handshake and drives the array's west inputs. Row r is delayed by r cycles to form the diagonal wavefront the array requires. After the last vector of a frame, it drains the skew pipeline and then signals frame completion.

## Interface
- ROWS, 4, number of array rows (west lanes), 1..16
- DATA_SIZE, 8, activation width in bits; each west lane is 2*DATA_SIZE wide
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream vector valid
- in_ready  out  1  feeder can accept a vector this cycle
- in_data  in  ROWS*DATA_SIZE  activations; lane r = bits [r*DATA_SIZE +: DATA_SIZE]
- in_last  in  1  qualifies the final vector of a frame; sampled only on accept
- data_west_out  out  ROWS*2*DATA_SIZE  skewed activations to array row r, lane r = bits [r*2*DATA_SIZE +: 2*DATA_SIZE]
- west_valid  out  ROWS  per-row valid marking real (non-bubble) data
- busy  out  1  state is not IDLE
- vec_count  out  32  vectors accepted in the current frame
- frame_done  out  1  one-cycle pulse when the last vector leaves row ROWS-1

## Operation
- Accept: a vector is accepted on a rising edge where in_valid && in_ready.
- State machine:
  - IDLE: in_ready=1. An accept without in_last moves to STREAM. An accept with in_last moves to DRAIN.
  - STREAM: in_ready=1. An accept with in_last moves to DRAIN. Otherwise the state is held.
  - DRAIN: in_ready=0. A down-counter is loaded with ROWS-1 on entry. The state moves to IDLE on the edge after the counter reaches 0.
- Skew pipeline: lane r is a chain of r+1 registers (data plus valid).
  - Stage 0 of every lane loads the accepted data with valid=1.
  - When nothing is accepted (any state), stage 0 loads zero with valid=0 (a bubble).
  - The array never stalls, so the pipeline shifts every cycle unconditionally.
- Width: each DATA_SIZE activation is extended to 2*DATA_SIZE. The extension type is set by the macro under Configuration. No truncation or saturation.
- vec_count:
  - An accept in IDLE loads 1.
  - An accept in STREAM increments the count, wrapping modulo 2^32.
  - The value is held through DRAIN and IDLE until the next frame starts.
- in_last while in_valid=0 is ignored. in_data is not sampled when no accept occurs.
- ROWS=1: no skew; DRAIN lasts one cycle.

## Timing
- Reset values: data_west_out=0, west_valid=0, busy=0, vec_count=0, frame_done=0, state IDLE.
  - in_ready=1 is derived combinationally from the IDLE state.
  - Reset asserted mid-frame clears all pipeline stages and the state immediately (asynchronous). Vectors in flight are discarded, and no frame_done is produced.
- Latency: a vector accepted at edge t appears on lane r at cycle t+1+r.
- DRAIN spans cycles t+1 .. t+ROWS after the last accept at edge t.
  - frame_done=1 during cycle t+ROWS, coincident with west_valid[ROWS-1] for the last vector.
  - in_ready returns to 1 in cycle t+ROWS+1.
- Back-to-back frames: the next frame's first accept can occur no earlier than cycle t+ROWS+1. There is no overlap between frames.
- busy is 1 from the cycle after the first accept through the frame_done cycle inclusive.
- in_ready depends only on state. There is no combinational path from in_valid to in_ready.

## Configuration
- ACT_SIGNED_EN defined: activations are signed two's complement and are sign-extended to 2*DATA_SIZE. Example: 8'hF0 becomes 16'hFFF0.
- ACT_SIGNED_EN undefined (default): activations are unsigned and zero-extended. Example: 8'hF0 becomes 16'h00F0.
- No other behaviour changes with the macro.

## Test plan
- Reset, ROWS=4: assert reset mid-cycle -> all outputs 0 and in_ready=1 asynchronously, without waiting for a clock edge.
- Single-vector frame, ROWS=4: in_data={8'h04,8'h03,8'h02,8'h01}, in_last=1, accepted at edge 10 -> lane0=16'h0001 at cycle 11 and lane3=16'h0004 at cycle 14. frame_done pulses at 14, in_ready=0 in cycles 11–14, vec_count=1.
- Streaming: 5 consecutive vectors 1..5 with in_last on the 5th -> each lane shows 1..5 on consecutive cycles offset by r. vec_count=5. frame_done fires 4 cycles after the 5th accept.
- Bubbles: in_valid toggles 1,0,1 -> one-cycle west_valid=0 gap with zero data on every lane, skewed by r. vec_count=2.
- Reset mid-frame: reset asserted 2 cycles after the first of 3 accepts -> pipeline cleared, no frame_done. A fresh frame afterwards starts with vec_count=1.
- Extension: in_data lane value 8'h80 -> 16'hFF80 with ACT_SIGNED_EN defined, 16'h0080 without it.
